// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: valid/ready handshake with a 2-entry skid buffer,
// flush to NOP bubble, and a saturating backpressure cycle counter.
module if_id_pipe #(
   parameter int                XLEN      = 32,
   parameter int                ILEN      = 32,
   parameter logic [ILEN-1:0]   NOP_INSTR = ILEN'(32'h0000_0013),
   parameter int                CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [XLEN-1:0]      if_pc,
   input  logic [ILEN-1:0]      if_instruction,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [XLEN-1:0]      id_pc,
   output logic [ILEN-1:0]      id_instruction,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 flush,
   output logic [CNT_WIDTH-1:0] stall_cycles
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t                r_state, w_nxt_state;
   logic [XLEN-1:0]       r_main_pc, w_nxt_main_pc;
   logic [ILEN-1:0]       r_main_instr, w_nxt_main_instr;
   logic [XLEN-1:0]       r_skid_pc, w_nxt_skid_pc;
   logic [ILEN-1:0]       r_skid_instr, w_nxt_skid_instr;
   logic [CNT_WIDTH-1:0]  r_stall_cnt;
   logic                  w_in_fire, w_out_fire;

   // Handshake outputs decode only the state register, so out_ready never
   // reaches in_ready combinationally.
   assign in_ready       = (r_state != TWO);
   assign out_valid      = (r_state != EMPTY);
   assign id_pc          = r_main_pc;
   assign id_instruction = r_main_instr;
   assign stall_cycles   = r_stall_cnt;

   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= EMPTY;
         r_main_pc    <= '0;
         r_main_instr <= NOP_INSTR;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_main_pc    <= w_nxt_main_pc;
         r_main_instr <= w_nxt_main_instr;
         r_skid_pc    <= w_nxt_skid_pc;
         r_skid_instr <= w_nxt_skid_instr;
      end
   end

   // The main entry is reloaded with the bubble whenever it empties, so id_*
   // shows {0, NOP} straight from the register while out_valid is low.
   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_main_pc    = r_main_pc;
      w_nxt_main_instr = r_main_instr;
      w_nxt_skid_pc    = r_skid_pc;
      w_nxt_skid_instr = r_skid_instr;
      if (flush) begin
         w_nxt_state      = EMPTY;
         w_nxt_main_pc    = '0;
         w_nxt_main_instr = NOP_INSTR;
         w_nxt_skid_pc    = '0;
         w_nxt_skid_instr = '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  w_nxt_state      = ONE;
                  w_nxt_main_pc    = if_pc;
                  w_nxt_main_instr = if_instruction;
               end
            end
            ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_nxt_main_pc    = if_pc;
                  w_nxt_main_instr = if_instruction;
               end else if (w_in_fire) begin
                  w_nxt_state      = TWO;
                  w_nxt_skid_pc    = if_pc;
                  w_nxt_skid_instr = if_instruction;
               end else if (w_out_fire) begin
                  w_nxt_state      = EMPTY;
                  w_nxt_main_pc    = '0;
                  w_nxt_main_instr = NOP_INSTR;
               end
            end
            TWO: begin
               if (w_out_fire) begin
                  w_nxt_state      = ONE;
                  w_nxt_main_pc    = r_skid_pc;
                  w_nxt_main_instr = r_skid_instr;
                  w_nxt_skid_pc    = '0;
                  w_nxt_skid_instr = '0;
               end
            end
            default: begin
               w_nxt_state      = EMPTY;
               w_nxt_main_pc    = '0;
               w_nxt_main_instr = NOP_INSTR;
            end
         endcase
      end
   end

   // Counts every stalled edge regardless of flush; only reset clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_stall_cnt <= '0;
      else if (out_valid && !out_ready && (r_stall_cnt != {CNT_WIDTH{1'b1}}))
         r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
   end

endmodule
